// File: rtl/onehot_pulse_decoder_pkg.sv
// rtl/onehot_pulse_decoder_pkg.sv - shared types and helpers for the one-hot pulse decoder
package onehot_pulse_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Widest one-hot vector the helper can build (IN_W up to 8).
    localparam int MAX_OUT_W = 256;

    // Single bit set at position 'code'; callers truncate to their own width.
    function automatic logic [MAX_OUT_W-1:0] to_onehot(input int code);
        return MAX_OUT_W'(1) << code;
    endfunction

    // Ceiling log2; returns 0 for values 0 and 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/onehot_pulse_decoder_sat_counter.sv
// rtl/onehot_pulse_decoder_sat_counter.sv - saturating event counter with clear priority
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);

    // Count up on inc, hold at all-ones; reset and clear both win over inc.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + CNT_W'(1);
        end
    end

endmodule

// File: rtl/onehot_pulse_decoder.sv
// rtl/onehot_pulse_decoder.sv - code-to-one-hot strobe generator with pulse/gap timing and event counters
module onehot_pulse_decoder
    import onehot_pulse_decoder_pkg::*;
#(
    parameter  int IN_W      = 2,
    parameter  int PULSE_LEN = 4,
    parameter  int GAP_LEN   = 1,
    parameter  int CNT_W     = 8,
    localparam int OUT_W     = 2 ** IN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_code,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_onehot,
    output logic             out_active,
    output logic             busy,
    input  logic             cnt_clr,
    input  logic [IN_W-1:0]  cnt_sel,
    output logic [CNT_W-1:0] cnt_value
);

    // Timer must hold both PULSE_LEN-1 and GAP_LEN-1.
    localparam int TW = max3(clog2(PULSE_LEN), clog2(GAP_LEN), 1);

    if (PULSE_LEN < 1) begin : g_bad_pulse_len
        $error("onehot_pulse_decoder: PULSE_LEN must be at least 1");
    end
    if (GAP_LEN < 0) begin : g_bad_gap_len
        $error("onehot_pulse_decoder: GAP_LEN must not be negative");
    end
    if (IN_W < 1 || IN_W > 8) begin : g_bad_in_w
        $error("onehot_pulse_decoder: IN_W must be between 1 and 8");
    end

    state_t            state;
    state_t            state_n;
    logic [TW-1:0]     timer;
    logic [TW-1:0]     timer_n;
    logic [IN_W-1:0]   code_q;
    logic [IN_W-1:0]   code_n;
    logic [OUT_W-1:0]  onehot_q;
    logic              accept;
    logic [OUT_W-1:0]  inc;
    logic [CNT_W-1:0]  cnt [OUT_W];

    // Ready only in IDLE, and never while reset is held.
    assign in_ready   = (state == IDLE) && !rst;
    assign accept     = in_valid && in_ready;
    assign busy       = (state != IDLE);
    assign out_onehot = onehot_q;
    assign out_active = |onehot_q;

    // Next-state, timer and captured-code logic for the IDLE/DRIVE/GAP sequence.
    always_comb begin
        state_n = state;
        timer_n = timer;
        code_n  = code_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = DRIVE;
                    timer_n = TW'(PULSE_LEN - 1);
                    code_n  = in_code;
                end
            end
            DRIVE: begin
                if (timer == '0) begin
                    if (GAP_LEN > 0) begin
                        state_n = GAP;
                        timer_n = TW'(GAP_LEN - 1);
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            GAP: begin
                if (timer == '0) begin
                    state_n = IDLE;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                timer_n = '0;
            end
        endcase
    end

    // State registers; the strobe is registered so it is glitch-free and exactly one cycle behind the accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            code_q   <= '0;
            onehot_q <= '0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            code_q   <= code_n;
            onehot_q <= (state_n == DRIVE) ? OUT_W'(to_onehot(int'(code_n))) : '0;
        end
    end

    for (genvar i = 0; i < OUT_W; i++) begin : g_cnt
        assign inc[i] = accept && (in_code == IN_W'(i));

        sat_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr   (cnt_clr),
            .inc   (inc[i]),
            .value (cnt[i])
        );
    end

    assign cnt_value = cnt[cnt_sel];

endmodule
